// File: rtl/frame_stream_pkg.sv
// Shared definitions for the frame streaming source: FSM states, widths and the pixel beat layout.
package frame_stream_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0]   val;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_beat_t;

    localparam int BEAT_W = $bits(pixel_beat_t);

endpackage

// File: rtl/frame_stream_source_fifo.sv
// First-word-fall-through FIFO: dout always shows the oldest entry while not empty.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees the slot this cycle, so a push into a full FIFO is fine alongside it.
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_stream_source.sv
// Streams one frame from a synchronous RAM in raster order through a credit-limited FIFO.
// Optional FRAME_FLUSH_EN appends FLUSH_PIX zero pixels after the frame.
module frame_stream_source
    import frame_stream_pkg::*;
#(
    parameter int ROW_SZ     = 320,
    parameter int COL_SZ     = 240,
    parameter int ADDR_W     = 17,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
`ifdef FRAME_FLUSH_EN
    ,
    parameter int FLUSH_PIX  = 960
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic [PIX_W-1:0]   out_val,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               is_out_val,
    input  logic               out_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int SUM_W = CNT_W + 1;

    state_e             state;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [SUM_W-1:0]   credit_sum;
    logic [RD_LAT-1:0]  pipe_v;
    logic [COORD_W-1:0] pipe_x [RD_LAT];
    logic [COORD_W-1:0] pipe_y [RD_LAT];
    logic               issue;
    logic               advance;
    logic               last_pos;
    logic               pipe_exit;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_drained;
    logic               flush_push;
    pixel_beat_t        fifo_din;
    pixel_beat_t        fifo_dout;

    // Reads in flight plus buffered beats never exceed the FIFO depth, so returns always fit.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue      = (state == FETCH) && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign rd_en      = issue;
    assign rd_addr    = addr_cnt;
    assign last_pos   = (x_cnt == COORD_W'(ROW_SZ-1)) && (y_cnt == COORD_W'(COL_SZ-1));
    assign pipe_exit  = pipe_v[RD_LAT-1];

    assign is_out_val   = !fifo_empty;
    assign fifo_pop     = is_out_val && out_ready;
    assign fifo_drained = fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop);

`ifdef FRAME_FLUSH_EN
    localparam int FLUSH_W = $clog2(FLUSH_PIX+1);
    logic [FLUSH_W-1:0] flush_cnt;
    logic               flush_left;

    assign flush_left = (flush_cnt != FLUSH_W'(FLUSH_PIX));
    assign flush_push = (state == FLUSH) && flush_left && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            flush_cnt <= '0;
        end else if (flush_push) begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
        end
    end
`else
    assign flush_push = 1'b0;
`endif

    assign advance       = issue || flush_push;
    assign fifo_push     = (pipe_exit && (!fifo_full || fifo_pop)) || flush_push;
    assign fifo_din.val  = pipe_exit ? rd_data : '0;
    assign fifo_din.x    = pipe_exit ? pipe_x[RD_LAT-1] : x_cnt;
    assign fifo_din.y    = pipe_exit ? pipe_y[RD_LAT-1] : y_cnt;

    assign out_val    = fifo_empty ? '0 : fifo_dout.val;
    assign out_x      = fifo_empty ? '0 : fifo_dout.x;
    assign out_y      = fifo_empty ? '0 : fifo_dout.y;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state <= FETCH;
                FETCH: if (issue && last_pos) state <= DRAIN;
                DRAIN: if (inflight == '0 && fifo_drained) begin
`ifdef FRAME_FLUSH_EN
                    state <= FLUSH;
`else
                    state <= DONE;
`endif
                end
`ifdef FRAME_FLUSH_EN
                FLUSH: if (!flush_left && fifo_drained) state <= DONE;
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Coordinates wrap back to (0,0) after the last position so flush beats continue raster order.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
            inflight <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                addr_cnt <= base_addr;
            end else begin
                if (advance) begin
                    if (x_cnt == COORD_W'(ROW_SZ-1)) begin
                        x_cnt <= '0;
                        y_cnt <= (y_cnt == COORD_W'(COL_SZ-1)) ? '0 : y_cnt + COORD_W'(1);
                    end else begin
                        x_cnt <= x_cnt + COORD_W'(1);
                    end
                end
                if (issue) addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            case ({issue, pipe_exit})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_x[0] <= x_cnt;
        pipe_y[0] <= y_cnt;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pipe_exit && fifo_full && !fifo_pop));
        end
    end

    stream_fifo #(
        .WIDTH(BEAT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on an 8x4 frame with a 2-cycle RAM where RAM[a]=a[7:0].
module tb_frame_stream_source;

    localparam int ROW = 8;
    localparam int COL = 4;
    localparam int PIX = ROW * COL;
`ifdef FRAME_FLUSH_EN
    localparam int TOTAL = PIX + 24;
`else
    localparam int TOTAL = PIX;
`endif
    localparam int BUDGET = 400;

    logic        clk;
    logic        reset;
    logic        start;
    logic [16:0] base_addr;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  out_val;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        is_out_val;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  ram_q1;

    int total = 0;
    int bad   = 0;

    frame_stream_source #(
        .ROW_SZ    (ROW),
        .COL_SZ    (COL),
        .ADDR_W    (17),
        .RD_LAT    (2),
        .FIFO_DEPTH(4)
`ifdef FRAME_FLUSH_EN
        ,
        .FLUSH_PIX (24)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_val   (out_val),
        .out_x     (out_x),
        .out_y     (out_y),
        .is_out_val(is_out_val),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage RAM model: data for an address appears two edges after it is presented.
    always @(posedge clk) begin
        ram_q1  <= rd_addr[7:0];
        rd_data <= ram_q1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: always ready; 1: random ready; 2: not ready for the first 20 cycles.
    task automatic applyStimulus(input int base, input int mode, input int restart_at, input int abort_at);
        int   n = 0;
        int   issued = 0;
        int   cyc = 0;
        logic done_seen = 1'b0;
        logic last_xfer = 1'b0;
        logic stalled = 1'b0;
        logic restarted = 1'b0;
        logic rdy;
        logic [27:0] held;
        logic [7:0]  ev;
        base_addr = 17'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < BUDGET) begin
            cyc++;
            start = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc > 20);
            endcase
            out_ready = rdy;
            checkOutput("frame_done", 64'(frame_done), 64'(last_xfer));
            checkOutput("busy", 64'(busy), 64'd1);
            if (frame_done === 1'b1) done_seen = 1'b1;
            if (rd_en === 1'b1) begin
                checkOutput("rd_addr", 64'(rd_addr), 64'(17'(base + issued)));
                checkOutput("credit", 64'((issued - n) < 4 && issued < PIX), 64'd1);
                issued++;
            end
            if (cyc == 3) checkOutput("latency_pre", 64'(is_out_val), 64'd0);
            if (cyc == 4) checkOutput("latency_first", 64'(is_out_val), 64'd1);
            if (mode == 2 && cyc == 20) checkOutput("stall_reads", 64'(issued), 64'd4);
            if (stalled) checkOutput("stall_hold", 64'({is_out_val, out_val, out_x, out_y}), 64'({1'b1, held}));
            last_xfer = 1'b0;
            if (is_out_val === 1'b1 && rdy) begin
                ev = (n < PIX) ? 8'(base + n) : 8'd0;
                checkOutput("beat", 64'({out_val, out_x, out_y}), 64'({ev, 10'(n % ROW), 10'((n / ROW) % COL)}));
                last_xfer = (n == TOTAL - 1);
                n++;
            end
            stalled = (is_out_val === 1'b1) && !rdy;
            held = {out_val, out_x, out_y};
            if (n == restart_at && !restarted) begin
                start = 1'b1;
                base_addr = 17'd99;
                restarted = 1'b1;
            end
            if (n == abort_at) break;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (abort_at < 0) begin
            checkOutput("timeout", 64'(done_seen), 64'd1);
            checkOutput("beat_count", 64'(n), 64'(TOTAL));
            checkOutput("read_count", 64'(issued), 64'(PIX));
            checkOutput("idle_after", 64'({busy, frame_done}), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 64'({rd_en, rd_addr, out_val, out_x, out_y, is_out_val, busy, frame_done}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic frame");
        applyStimulus(16, 0, -1, -1);
        $display("[TB] random backpressure");
        applyStimulus(16, 1, -1, -1);
        $display("[TB] initial 20-cycle stall");
        applyStimulus(16, 2, -1, -1);
        $display("[TB] start pulsed while busy");
        applyStimulus(16, 0, 10, -1);
        $display("[TB] reset mid-frame");
        applyStimulus(16, 0, -1, 12);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_mid", 64'({rd_en, rd_addr, out_val, out_x, out_y, is_out_val, busy, frame_done}), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("no_stale", 64'({is_out_val, busy}), 64'd0);
        applyStimulus(0, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
